llc_req_in_rx: RTL and testbench

LLC_REQ_IN_RX -- requirements
Module: llc_req_in_rx

---
 rtl/llc_req_in_rx.sv | 120 ++++++++++++
 tb/tb_llc_req_in_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/llc_req_in_rx.sv
// Buffers L2 requests toward the LLC in a DEPTH-entry FIFO with registered, bypass-free head outputs.
// Define LLC_REQ_RX_STATS_EN to add saturating per-type push counters.
module llc_req_in_rx #(
    parameter int DEPTH   = 4,
    parameter int HPROT_W = 1,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int REQ_W  = 2 + HPROT_W + ADDR_W + LINE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                l2_req_out_valid,
    output logic                l2_req_out_ready,
    input  logic [REQ_W-1:0]    l2_req_out_i,
    output logic                llc_req_in_valid,
    input  logic                llc_req_in_ready,
    output logic [1:0]          llc_req_in_coh_msg,
    output logic [HPROT_W-1:0]  llc_req_in_hprot,
    output logic [ADDR_W-1:0]   llc_req_in_addr,
    output logic [LINE_W-1:0]   llc_req_in_line,
    output logic [3:0]          llc_req_in_type,
    output logic                llc_req_in_has_data,
    output logic [CNT_W-1:0]    fifo_count
`ifdef LLC_REQ_RX_STATS_EN
    ,
    output logic [31:0]         stat_gets,
    output logic [31:0]         stat_getm,
    output logic [31:0]         stat_puts,
    output logic [31:0]         stat_putm
`endif
);

    // l2_req_out_i packs {coh_msg, hprot, addr, line}, line in the LSBs.
    // Valid/ready: a beat transfers on a rising edge where valid && ready;
    // the sender holds valid and payload stable until it transfers.
    localparam logic [1:0] PUTM = 2'b11;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, show;
    logic [1:0]       in_coh;
    logic [REQ_W-1:0] in_entry;
    logic [REQ_W-1:0] head;

    assign in_coh = l2_req_out_i[REQ_W-1 -: 2];

    // Lines of non-PUTM requests are never stored, so the head sees zero.
    always_comb begin
        in_entry = l2_req_out_i;
        if (in_coh != PUTM) in_entry[LINE_W-1:0] = '0;
    end

    // Ready and valid depend only on registered count and rst, never on llc_req_in_ready.
    assign l2_req_out_ready = !rst && (count_q < DEPTH_C);
    assign show             = !rst && (count_q != '0);
    assign llc_req_in_valid = show;
    assign push             = l2_req_out_valid && l2_req_out_ready;
    assign pop              = show && llc_req_in_ready;
    assign fifo_count       = rst ? '0 : count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign head = show ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        llc_req_in_coh_msg  = head[REQ_W-1 -: 2];
        llc_req_in_hprot    = head[LINE_W+ADDR_W +: HPROT_W];
        llc_req_in_addr     = head[LINE_W +: ADDR_W];
        llc_req_in_line     = head[LINE_W-1:0];
        llc_req_in_type     = show ? (4'b0001 << head[REQ_W-1 -: 2]) : 4'b0000;
        llc_req_in_has_data = show && (head[REQ_W-1 -: 2] == PUTM);
    end

`ifdef LLC_REQ_RX_STATS_EN
    logic [31:0] stat_q [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
        end else if (push && (stat_q[in_coh] != 32'hFFFF_FFFF)) begin
            stat_q[in_coh] <= stat_q[in_coh] + 32'd1;
        end
    end

    assign stat_gets = stat_q[0];
    assign stat_getm = stat_q[1];
    assign stat_puts = stat_q[2];
    assign stat_putm = stat_q[3];
`endif

endmodule

// File: tb/tb_llc_req_in_rx.sv
// Scoreboard bench for llc_req_in_rx: directed scenarios then randomized traffic with resets.
// Build with LLC_REQ_RX_STATS_EN to also check the per-type counters.
module tb_llc_req_in_rx;
    localparam int DEPTH   = 4;
    localparam int HPROT_W = 1;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int W       = 2 + HPROT_W + ADDR_W + LINE_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                l2_req_out_valid = 1'b0;
    logic                l2_req_out_ready;
    logic [W-1:0]        l2_req_out_i = '0;
    logic                llc_req_in_valid;
    logic                llc_req_in_ready = 1'b0;
    logic [1:0]          llc_req_in_coh_msg;
    logic [HPROT_W-1:0]  llc_req_in_hprot;
    logic [ADDR_W-1:0]   llc_req_in_addr;
    logic [LINE_W-1:0]   llc_req_in_line;
    logic [3:0]          llc_req_in_type;
    logic                llc_req_in_has_data;
    logic [CNT_W-1:0]    fifo_count;
`ifdef LLC_REQ_RX_STATS_EN
    logic [31:0] stat_gets, stat_getm, stat_puts, stat_putm;
`endif

    logic [W-1:0] exp_q[$];
    int           exp_stat[4];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] e;

    llc_req_in_rx #(.DEPTH(DEPTH), .HPROT_W(HPROT_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .l2_req_out_valid    (l2_req_out_valid),
        .l2_req_out_ready    (l2_req_out_ready),
        .l2_req_out_i        (l2_req_out_i),
        .llc_req_in_valid    (llc_req_in_valid),
        .llc_req_in_ready    (llc_req_in_ready),
        .llc_req_in_coh_msg  (llc_req_in_coh_msg),
        .llc_req_in_hprot    (llc_req_in_hprot),
        .llc_req_in_addr     (llc_req_in_addr),
        .llc_req_in_line     (llc_req_in_line),
        .llc_req_in_type     (llc_req_in_type),
        .llc_req_in_has_data (llc_req_in_has_data),
        .fifo_count          (fifo_count)
`ifdef LLC_REQ_RX_STATS_EN
        ,
        .stat_gets           (stat_gets),
        .stat_getm           (stat_getm),
        .stat_puts           (stat_puts),
        .stat_putm           (stat_putm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // What the LLC should see for a request: line kept only for PUTM.
    function automatic logic [W-1:0] expected_of(input logic [W-1:0] r);
        logic [W-1:0] x;
        x = r;
        if (r[W-1 -: 2] != 2'b11) x[LINE_W-1:0] = '0;
        return x;
    endfunction

    function automatic logic [W-1:0] mk_req(input logic [1:0] coh, input logic [ADDR_W-1:0] addr,
                                            input logic [LINE_W-1:0] line);
        logic [HPROT_W-1:0] hp;
        hp = HPROT_W'($urandom_range(0, 1));
        return {coh, hp, addr, line};
    endfunction

    function automatic logic [W-1:0] rand_req();
        return mk_req(2'($urandom_range(0, 3)), $urandom,
                      {$urandom, $urandom, $urandom, $urandom});
    endfunction

    // Monitor: compares DUT outputs against the model queue every cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 256'(l2_req_out_ready), 256'(0));
            chk("rst_valid", 256'(llc_req_in_valid), 256'(0));
            chk("rst_count", 256'(fifo_count), 256'(0));
            chk("rst_head", 256'({llc_req_in_coh_msg, llc_req_in_hprot, llc_req_in_addr,
                                  llc_req_in_line, llc_req_in_type, llc_req_in_has_data}), 256'(0));
            exp_q.delete();
            for (int i = 0; i < 4; i++) exp_stat[i] = 0;
        end else begin
            chk("count", 256'(fifo_count), 256'(exp_q.size()));
            chk("in_ready", 256'(l2_req_out_ready), 256'(exp_q.size() < DEPTH));
            chk("out_valid", 256'(llc_req_in_valid), 256'(exp_q.size() != 0));
`ifdef LLC_REQ_RX_STATS_EN
            chk("stat_gets", 256'(stat_gets), 256'(exp_stat[0]));
            chk("stat_getm", 256'(stat_getm), 256'(exp_stat[1]));
            chk("stat_puts", 256'(stat_puts), 256'(exp_stat[2]));
            chk("stat_putm", 256'(stat_putm), 256'(exp_stat[3]));
`endif
            if (exp_q.size() == 0) begin
                chk("empty_head", 256'({llc_req_in_coh_msg, llc_req_in_hprot, llc_req_in_addr,
                                        llc_req_in_line, llc_req_in_type, llc_req_in_has_data}),
                    256'(0));
            end else begin
                e = exp_q[0];
                chk("head", 256'({llc_req_in_coh_msg, llc_req_in_hprot, llc_req_in_addr,
                                  llc_req_in_line}), 256'(e));
                chk("type", 256'(llc_req_in_type), 256'(4'b0001 << e[W-1 -: 2]));
                chk("has_data", 256'(llc_req_in_has_data), 256'(e[W-1 -: 2] == 2'b11));
                if (llc_req_in_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of the L2 side; records the request in the model if it transferred.
    task automatic tick(output logic acc);
        @(negedge clk);
        acc = l2_req_out_valid && l2_req_out_ready;
        @(posedge clk);
        if (acc) begin
            exp_q.push_back(expected_of(l2_req_out_i));
            exp_stat[l2_req_out_i[W-1 -: 2]]++;
        end
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] r);
        logic acc;
        int   n;
        n = 0;
        acc = 1'b0;
        l2_req_out_i = r;
        l2_req_out_valid = 1'b1;
        while (!acc && n < 200) begin
            tick(acc);
            n++;
        end
        l2_req_out_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=not_accepted exp=accepted t=%0t", $time);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        cycles(3);
        rst = 1'b0;
        cycles(1);

        // Single GETS, then a PUTM with a full line
        send(mk_req(2'b00, 32'h100, {4{32'h5555_AAAA}}));
        cycles(1);
        llc_req_in_ready = 1'b1;
        cycles(2);
        llc_req_in_ready = 1'b0;
        send(mk_req(2'b11, 32'h2A0, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF));
        cycles(1);
        llc_req_in_ready = 1'b1;
        cycles(2);
        llc_req_in_ready = 1'b0;

        // Fill to full with the LLC stalled; the fifth is held until one pop
        for (int i = 0; i < 4; i++) send(rand_req());
        fork
            send(rand_req());
            begin
                cycles(3);
                llc_req_in_ready = 1'b1;
                cycles(1);
                llc_req_in_ready = 1'b0;
            end
        join
        cycles(2);
        llc_req_in_ready = 1'b1;
        cycles(DEPTH + 2);

        // Streaming across pointer wrap
        for (int i = 0; i < 12; i++) send(rand_req());
        cycles(DEPTH + 2);

        // Reset with three entries buffered
        llc_req_in_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_req());
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(1);
        llc_req_in_ready = 1'b1;
        cycles(2);

        // Two GETM and one PUTS after a clean reset
        send(mk_req(2'b01, 32'h40, {4{$urandom}}));
        send(mk_req(2'b01, 32'h80, {4{$urandom}}));
        send(mk_req(2'b10, 32'hC0, {4{$urandom}}));
        cycles(3);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if (!l2_req_out_valid && $urandom_range(0, 3) != 0) begin
                l2_req_out_i = rand_req();
                l2_req_out_valid = 1'b1;
            end
            llc_req_in_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick(acc);
            if (acc) l2_req_out_valid = 1'b0;
        end
        rst = 1'b0;
        l2_req_out_valid = 1'b0;
        llc_req_in_ready = 1'b1;
        cycles(DEPTH + 3);
        chk("drained", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
